// File: rtl/binary_to_bcd_if.sv
// Valid/ready bundle between a binary producer and the sequential BCD converter.
// The converter connects through the slave modport; the producer uses master.
interface binary_to_bcd_if #(
   parameter int BIN_W      = 8,
   parameter int BCD_DIGITS = 3
);
   logic                    in_valid;
   logic                    in_ready;
   logic [BIN_W-1:0]        in_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [4*BCD_DIGITS-1:0] out_bcd;
   logic                    out_neg;
   logic                    out_overflow;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_bcd, out_neg, out_overflow
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_bcd, out_neg, out_overflow
   );
endinterface

// File: rtl/binary_to_bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock,
// with optional two's-complement input and saturation when the digits run out.
module binary_to_bcd_seq #(
   parameter int BIN_W       = 8,
   parameter int BCD_DIGITS  = 3,
   parameter int SIGNED_MODE = 0
) (
   input logic             clk,
   input logic             rst,
   binary_to_bcd_if.slave  io_bus
);

   localparam int BW    = 4 * BCD_DIGITS;
   localparam int CW    = BIN_W + BW;
   localparam int CNT_W = $clog2(BIN_W + 1);

   function automatic logic [CW-1:0] f_pow10(input int n);
      logic [CW-1:0] p;
      p = CW'(1);
      for (int i = 0; i < n; i++) p = p * CW'(10);
      return p;
   endfunction

   // 10**BCD_DIGITS always fits in CW bits since 10**D < 2**(4*D)
   localparam logic [CW-1:0] LIMIT = f_pow10(BCD_DIGITS);

   function automatic logic [BW-1:0] f_dabble(input logic [BW-1:0] bcd);
      logic [BW-1:0] res;
      res = bcd;
      for (int d = 0; d < BCD_DIGITS; d++)
         if (bcd[4*d +: 4] >= 4'd5) res[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      return res;
   endfunction

   function automatic logic [BW-1:0] f_saturate(input logic [BW-1:0] bcd, input logic ovf);
      return ovf ? {BCD_DIGITS{4'h9}} : bcd;
   endfunction

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [BIN_W-1:0]        r_bin;
   logic [BW-1:0]           r_bcd;
   logic [CNT_W-1:0]        r_cnt;
   logic                    r_neg;
   logic                    r_ovf;
   logic [BW-1:0]           r_out_bcd;
   logic                    r_out_neg;
   logic                    r_out_ovf;

   logic                    w_accept;
   logic                    w_in_neg;
   logic signed [BIN_W-1:0] w_sdata;
   logic [BIN_W-1:0]        w_mag;
   logic                    w_mag_ovf;
   logic [BW-1:0]           w_bcd_adj;
   logic [BW+BIN_W-1:0]     w_shift;

   assign w_accept  = (r_state == S_IDLE) && io_bus.in_valid;
   assign w_sdata   = io_bus.in_data;
   assign w_in_neg  = (SIGNED_MODE != 0) && io_bus.in_data[BIN_W-1];
   // Negating the most negative value wraps to 2**(BIN_W-1), which is the correct unsigned magnitude
   assign w_mag     = w_in_neg ? $unsigned(-w_sdata) : io_bus.in_data;
   assign w_mag_ovf = ({{BW{1'b0}}, w_mag} >= LIMIT);
   assign w_bcd_adj = f_dabble(r_bcd);
   assign w_shift   = {w_bcd_adj, r_bin} << 1;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (io_bus.in_valid) w_state_nxt = S_SHIFT;
         S_SHIFT: if (r_cnt == '0) w_state_nxt = S_DONE;
         S_DONE:  if (io_bus.out_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_bin     <= '0;
         r_bcd     <= '0;
         r_cnt     <= '0;
         r_neg     <= 1'b0;
         r_ovf     <= 1'b0;
         r_out_bcd <= '0;
         r_out_neg <= 1'b0;
         r_out_ovf <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_bin <= w_mag;
                  r_bcd <= '0;
                  r_cnt <= CNT_W'(BIN_W);
                  r_neg <= w_in_neg;
                  r_ovf <= w_mag_ovf;
               end
            end
            S_SHIFT: begin
               // Shift while bits remain; the extra cycle at zero registers the result
               if (r_cnt != '0) begin
                  r_bcd <= w_shift[BW+BIN_W-1 -: BW];
                  r_bin <= w_shift[BIN_W-1:0];
                  r_cnt <= r_cnt - CNT_W'(1);
               end else begin
                  r_out_bcd <= f_saturate(r_bcd, r_ovf);
                  r_out_neg <= r_neg;
                  r_out_ovf <= r_ovf;
               end
            end
            default: ;
         endcase
      end
   end

   assign io_bus.in_ready     = (r_state == S_IDLE);
   assign io_bus.out_valid    = (r_state == S_DONE);
   assign io_bus.out_bcd      = r_out_bcd;
   assign io_bus.out_neg      = r_out_neg;
   assign io_bus.out_overflow = r_out_ovf;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Directed bench for binary_to_bcd_seq across four parameter sets sharing one clock and reset.
module tb_binary_to_bcd_seq;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   binary_to_bcd_if #(.BIN_W(8),  .BCD_DIGITS(3)) if_a ();
   binary_to_bcd_if #(.BIN_W(8),  .BCD_DIGITS(3)) if_b ();
   binary_to_bcd_if #(.BIN_W(8),  .BCD_DIGITS(2)) if_c ();
   binary_to_bcd_if #(.BIN_W(16), .BCD_DIGITS(5)) if_d ();

   binary_to_bcd_seq #(.BIN_W(8),  .BCD_DIGITS(3), .SIGNED_MODE(0)) u_a (.clk(clk), .rst(rst), .io_bus(if_a.slave));
   binary_to_bcd_seq #(.BIN_W(8),  .BCD_DIGITS(3), .SIGNED_MODE(1)) u_b (.clk(clk), .rst(rst), .io_bus(if_b.slave));
   binary_to_bcd_seq #(.BIN_W(8),  .BCD_DIGITS(2), .SIGNED_MODE(0)) u_c (.clk(clk), .rst(rst), .io_bus(if_c.slave));
   binary_to_bcd_seq #(.BIN_W(16), .BCD_DIGITS(5), .SIGNED_MODE(0)) u_d (.clk(clk), .rst(rst), .io_bus(if_d.slave));

   task automatic drive(input int sel, input logic v, input logic [15:0] d);
      case (sel)
         0: begin if_a.in_valid = v; if_a.in_data = d[7:0]; end
         1: begin if_b.in_valid = v; if_b.in_data = d[7:0]; end
         2: begin if_c.in_valid = v; if_c.in_data = d[7:0]; end
         default: begin if_d.in_valid = v; if_d.in_data = d; end
      endcase
   endtask

   function automatic logic f_valid(input int sel);
      case (sel)
         0: return if_a.out_valid;
         1: return if_b.out_valid;
         2: return if_c.out_valid;
         default: return if_d.out_valid;
      endcase
   endfunction

   function automatic logic f_ready(input int sel);
      case (sel)
         0: return if_a.in_ready;
         1: return if_b.in_ready;
         2: return if_c.in_ready;
         default: return if_d.in_ready;
      endcase
   endfunction

   function automatic logic [21:0] f_result(input int sel);
      case (sel)
         0: return {if_a.out_neg, if_a.out_overflow, 8'h0, if_a.out_bcd};
         1: return {if_b.out_neg, if_b.out_overflow, 8'h0, if_b.out_bcd};
         2: return {if_c.out_neg, if_c.out_overflow, 12'h0, if_c.out_bcd};
         default: return {if_d.out_neg, if_d.out_overflow, if_d.out_bcd};
      endcase
   endfunction

   // Accepts one value, returns the result and the edge count from accept to out_valid (-1 on timeout)
   task automatic convert(input int sel, input logic [15:0] d, output logic [19:0] bcd,
                          output logic neg, output logic ovf, output int lat, output logic busy_ok);
      logic [21:0] r;
      @(negedge clk);
      drive(sel, 1'b1, d);
      @(posedge clk);
      #1;
      drive(sel, 1'b0, 16'h0);
      lat     = -1;
      busy_ok = !f_ready(sel);
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         if (f_ready(sel)) busy_ok = 1'b0;
         if (f_valid(sel)) begin
            lat = n;
            break;
         end
      end
      r   = f_result(sel);
      neg = r[21];
      ovf = r[20];
      bcd = r[19:0];
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      checks++;
      if ({if_a.in_ready, if_a.out_valid, if_a.out_bcd, if_a.out_neg, if_a.out_overflow} !== {1'b1, 1'b0, 12'h000, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_a rdy=%b vld=%b bcd=%h neg=%b ovf=%b want 1 0 000 0 0",
                  if_a.in_ready, if_a.out_valid, if_a.out_bcd, if_a.out_neg, if_a.out_overflow);
      end
      checks++;
      if ({if_d.in_ready, if_d.out_valid, if_d.out_bcd} !== {1'b1, 1'b0, 20'h00000}) begin
         errors++;
         $display("FAIL reset_d rdy=%b vld=%b bcd=%h want 1 0 00000", if_d.in_ready, if_d.out_valid, if_d.out_bcd);
      end
   endtask

   task automatic test_max_latency();
      logic [19:0] bcd; logic neg, ovf, busy; int lat;
      convert(0, 16'd255, bcd, neg, ovf, lat, busy);
      checks++;
      if (bcd[11:0] !== 12'h255 || lat !== 9) begin
         errors++;
         $display("FAIL max255 bcd=%h lat=%0d want 255 lat 9", bcd[11:0], lat);
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL max255_busy in_ready went high during conversion, got %b want 1", busy);
      end
   endtask

   task automatic test_sweep();
      logic [19:0] bcd; logic neg, ovf, busy; int lat;
      logic [11:0] want;
      for (int v = 0; v < 256; v++) begin
         want = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
         convert(0, 16'(v), bcd, neg, ovf, lat, busy);
         checks++;
         if ({bcd[11:0], neg, ovf} !== {want, 1'b0, 1'b0} || lat !== 9) begin
            errors++;
            $display("FAIL sweep v=%0d bcd=%h neg=%b ovf=%b lat=%0d want %h 0 0 lat 9", v, bcd[11:0], neg, ovf, lat, want);
         end
      end
   endtask

   task automatic test_signed();
      logic [19:0] bcd; logic neg, ovf, busy; int lat;
      logic [7:0]  ins  [4] = '{8'h80, 8'hFF, 8'h7F, 8'h00};
      logic [11:0] outs [4] = '{12'h128, 12'h001, 12'h127, 12'h000};
      logic        negs [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         convert(1, {8'h0, ins[i]}, bcd, neg, ovf, lat, busy);
         checks++;
         if ({bcd[11:0], neg, ovf} !== {outs[i], negs[i], 1'b0} || lat !== 9) begin
            errors++;
            $display("FAIL signed in=%h bcd=%h neg=%b ovf=%b lat=%0d want %h %b 0 lat 9",
                     ins[i], bcd[11:0], neg, ovf, lat, outs[i], negs[i]);
         end
      end
   endtask

   task automatic test_overflow();
      logic [19:0] bcd; logic neg, ovf, busy; int lat;
      logic [7:0] ins  [4] = '{8'd99, 8'd100, 8'd255, 8'd42};
      logic [7:0] outs [4] = '{8'h99, 8'h99, 8'h99, 8'h42};
      logic       ovfs [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         convert(2, {8'h0, ins[i]}, bcd, neg, ovf, lat, busy);
         checks++;
         if ({bcd[7:0], ovf, neg} !== {outs[i], ovfs[i], 1'b0} || lat !== 9) begin
            errors++;
            $display("FAIL overflow in=%0d bcd=%h ovf=%b neg=%b lat=%0d want %h %b 0 lat 9",
                     ins[i], bcd[7:0], ovf, neg, lat, outs[i], ovfs[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int n;
      if_a.out_ready = 1'b0;
      @(negedge clk);
      drive(0, 1'b1, 16'd37);
      @(posedge clk);
      #1;
      drive(0, 1'b0, 16'h0);
      n = 0;
      while (!if_a.out_valid && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (n !== 9) begin
         errors++;
         $display("FAIL bp_latency got %0d want 9", n);
      end
      @(negedge clk);
      drive(0, 1'b1, 16'd200);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if ({if_a.out_valid, if_a.in_ready, if_a.out_bcd} !== {1'b1, 1'b0, 12'h037}) begin
            errors++;
            $display("FAIL bp_hold cyc=%0d vld=%b rdy=%b bcd=%h want 1 0 037", i, if_a.out_valid, if_a.in_ready, if_a.out_bcd);
         end
      end
      @(negedge clk);
      if_a.out_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({if_a.out_valid, if_a.in_ready, if_a.out_bcd} !== {1'b0, 1'b1, 12'h037}) begin
         errors++;
         $display("FAIL bp_release vld=%b rdy=%b bcd=%h want 0 1 037", if_a.out_valid, if_a.in_ready, if_a.out_bcd);
      end
      // in_valid has been high all along, so this edge accepts 200
      @(posedge clk);
      #1;
      drive(0, 1'b0, 16'h0);
      checks++;
      if (if_a.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_accept in_ready=%b want 0", if_a.in_ready);
      end
      n = 0;
      while (!if_a.out_valid && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (if_a.out_bcd !== 12'h200 || n !== 9) begin
         errors++;
         $display("FAIL bp_next bcd=%h lat=%0d want 200 lat 9", if_a.out_bcd, n);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid_shift();
      logic [19:0] bcd; logic neg, ovf, busy; int lat;
      @(negedge clk);
      drive(0, 1'b1, 16'd123);
      @(posedge clk);
      #1;
      drive(0, 1'b0, 16'h0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({if_a.in_ready, if_a.out_valid, if_a.out_bcd, if_a.out_neg, if_a.out_overflow} !== {1'b1, 1'b0, 12'h000, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL mid_reset rdy=%b vld=%b bcd=%h neg=%b ovf=%b want 1 0 000 0 0",
                  if_a.in_ready, if_a.out_valid, if_a.out_bcd, if_a.out_neg, if_a.out_overflow);
      end
      @(negedge clk);
      rst = 1'b0;
      convert(0, 16'd42, bcd, neg, ovf, lat, busy);
      checks++;
      if (bcd[11:0] !== 12'h042 || lat !== 9) begin
         errors++;
         $display("FAIL after_reset bcd=%h lat=%0d want 042 lat 9", bcd[11:0], lat);
      end
   endtask

   task automatic test_wide();
      logic [19:0] bcd; logic neg, ovf, busy; int lat;
      convert(3, 16'd65535, bcd, neg, ovf, lat, busy);
      checks++;
      if ({bcd, ovf} !== {20'h65535, 1'b0} || lat !== 17) begin
         errors++;
         $display("FAIL wide65535 bcd=%h ovf=%b lat=%0d want 65535 0 lat 17", bcd, ovf, lat);
      end
      convert(3, 16'd10000, bcd, neg, ovf, lat, busy);
      checks++;
      if ({bcd, ovf} !== {20'h10000, 1'b0} || lat !== 17) begin
         errors++;
         $display("FAIL wide10000 bcd=%h ovf=%b lat=%0d want 10000 0 lat 17", bcd, ovf, lat);
      end
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 1'b0, 16'h0);
      drive(1, 1'b0, 16'h0);
      drive(2, 1'b0, 16'h0);
      drive(3, 1'b0, 16'h0);
      if_a.out_ready = 1'b1;
      if_b.out_ready = 1'b1;
      if_c.out_ready = 1'b1;
      if_d.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      rst = 1'b0;
      test_max_latency();
      test_sweep();
      test_signed();
      test_overflow();
      test_backpressure();
      test_reset_mid_shift();
      test_wide();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
